// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the shared memory/IO bus
// and the arbiter. The arbiter connects through the master modport; the
// requester/bus side (or a bench) uses the slave modport.
interface mem_port_arbiter_if;
  // fetch requester
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        i_err;
  // data requester
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_ctrl;
  logic        d_gnt;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;
  // shared bus
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [2:0]  bus_ctrl;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_ctrl, bus_rdata, bus_ready,
    output i_gnt, i_valid, i_rdata, i_err, d_gnt, d_valid, d_rdata, d_err,
           bus_req, bus_we, bus_addr, bus_wdata, bus_ctrl
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_ctrl, bus_rdata, bus_ready,
    input  i_gnt, i_valid, i_rdata, i_err, d_gnt, d_valid, d_rdata, d_err,
           bus_req, bus_we, bus_addr, bus_wdata, bus_ctrl
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer for the single shared memory/IO bus. One access at a
// time from either the fetch (I) or data (D) requester; the access is latched
// on acceptance, held on the bus until bus_ready, and a one-cycle valid pulse
// is returned to the winner. A watchdog aborts accesses that never complete.
module mem_port_arbiter #(
  parameter int unsigned  TIMEOUT  = 16,
  parameter logic [31:0]  ERR_DATA = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,   // asynchronous, active low
  mem_port_arbiter_if.master    mp,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS_I = 2'd1,
    ST_BUS_D = 2'd2
  } state_e;

  localparam logic [15:0] TMO   = 16'(TIMEOUT);
  localparam bit          WD_EN = (TIMEOUT != 0);

  state_e      state_q, state_d;
  logic        last_d_q, last_d_d;     // 1 = D won the previous grant
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] cnt_q, cnt_d;
  logic        i_valid_q, i_valid_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        i_err_q, i_err_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;

  logic        gnt_i_s, gnt_d_s;
  logic        fin_s, fin_err_s;
  logic [31:0] fin_data_s;

  // Arbitration, access latching, completion/watchdog and next-state logic.
  always_comb begin
    state_d    = state_q;
    last_d_d   = last_d_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    ctrl_d     = ctrl_q;
    cnt_d      = cnt_q;
    i_valid_d  = 1'b0;
    i_rdata_d  = i_rdata_q;
    i_err_d    = i_err_q;
    d_valid_d  = 1'b0;
    d_rdata_d  = d_rdata_q;
    d_err_d    = d_err_q;
    gnt_i_s    = 1'b0;
    gnt_d_s    = 1'b0;
    fin_s      = 1'b0;
    fin_err_s  = 1'b0;
    fin_data_s = mp.bus_rdata;

    case (state_q)
      ST_IDLE: begin
        // Contention goes to the side that did not win last time.
        if (mp.i_req && mp.d_req) begin
          gnt_i_s = last_d_q;
          gnt_d_s = ~last_d_q;
        end else begin
          gnt_i_s = mp.i_req;
          gnt_d_s = mp.d_req;
        end
        if (gnt_i_s) begin
          state_d  = ST_BUS_I;
          last_d_d = 1'b0;
          addr_d   = mp.i_addr;
          we_d     = 1'b0;
          wdata_d  = 32'h0000_0000;
          ctrl_d   = 3'b010;
          cnt_d    = 16'd0;
        end else if (gnt_d_s) begin
          state_d  = ST_BUS_D;
          last_d_d = 1'b1;
          addr_d   = mp.d_addr;
          we_d     = mp.d_we;
          wdata_d  = mp.d_wdata;
          ctrl_d   = mp.d_ctrl;
          cnt_d    = 16'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS_I, ST_BUS_D: begin
        // A ready arriving on the expiry edge still counts as a normal finish.
        if (mp.bus_ready) begin
          fin_s = 1'b1;
        end else if (WD_EN && ((cnt_q + 16'd1) == TMO)) begin
          fin_s      = 1'b1;
          fin_err_s  = 1'b1;
          fin_data_s = ERR_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fin_s) begin
      state_d = ST_IDLE;
      if (state_q == ST_BUS_I) begin
        i_valid_d = 1'b1;
        i_rdata_d = fin_data_s;
        i_err_d   = fin_err_s;
      end else begin
        d_valid_d = 1'b1;
        d_rdata_d = fin_data_s;
        d_err_d   = fin_err_s;
      end
    end else begin
      state_d = state_d;
    end
  end

  // State and latched-access registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      last_d_q  <= 1'b1;
      addr_q    <= 32'h0000_0000;
      we_q      <= 1'b0;
      wdata_q   <= 32'h0000_0000;
      ctrl_q    <= 3'b000;
      cnt_q     <= 16'd0;
      i_valid_q <= 1'b0;
      i_rdata_q <= 32'h0000_0000;
      i_err_q   <= 1'b0;
      d_valid_q <= 1'b0;
      d_rdata_q <= 32'h0000_0000;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
      i_valid_q <= i_valid_d;
      i_rdata_q <= i_rdata_d;
      i_err_q   <= i_err_d;
      d_valid_q <= d_valid_d;
      d_rdata_q <= d_rdata_d;
      d_err_q   <= d_err_d;
    end
  end

  assign mp.i_gnt     = gnt_i_s;
  assign mp.d_gnt     = gnt_d_s;
  assign mp.i_valid   = i_valid_q;
  assign mp.i_rdata   = i_rdata_q;
  assign mp.i_err     = i_err_q;
  assign mp.d_valid   = d_valid_q;
  assign mp.d_rdata   = d_rdata_q;
  assign mp.d_err     = d_err_q;
  assign busy         = (state_q != ST_IDLE);
  assign mp.bus_req   = busy;
  assign mp.bus_we    = busy & we_q;
  assign mp.bus_addr  = addr_q;
  assign mp.bus_wdata = wdata_q;
  assign mp.bus_ctrl  = ctrl_q;

endmodule
